// File: rtl/memory_stage.sv
// LEGv8 memory stage: EX/MEM register, branch resolve, req/ack data-memory access, MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned LDUR/STUR skip the access and flag misalign_M.
module memory_stage #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic [N-1:0] PCBranch_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic         zero_E,
   input  logic         Branch_E,
   input  logic         memRead_E,
   input  logic         memWrite_E,
   input  logic         regWrite_E,
   input  logic         memtoReg_E,
   input  logic [4:0]   rd_E,
   output logic         stall_M,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_M,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic [N-1:0] dm_rdata,
   input  logic         dm_ack,
   output logic [N-1:0] readData_W,
   output logic [N-1:0] aluResult_W,
   output logic [4:0]   rd_W,
   output logic         regWrite_W,
   output logic         memtoReg_W,
   output logic         misalign_M
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t       state, state_next;
   logic         valid_M, zero_M, Branch_M, memRead_M, memWrite_M, regWrite_M, memtoReg_M;
   logic [N-1:0] aluResult_M, writeData_M;
   logic [4:0]   rd_M;
   logic [N-1:0] rdata_q;
   logic         mem_op;

   assign mem_op   = valid_M & (memRead_M | memWrite_M);
   assign PCSrc_M  = valid_M & Branch_M & zero_M;
   assign dm_req   = (state == REQ);
   assign dm_we    = dm_req & memWrite_M;
   assign dm_addr  = aluResult_M;
   assign dm_wdata = writeData_M;

`ifdef MEM_ALIGN_CHECK_EN
   logic addr_bad;
   assign addr_bad   = |aluResult_M[2:0];
   assign misalign_M = (state == DONE) & mem_op & addr_bad;
`else
   assign misalign_M = 1'b0;
`endif

   always_comb begin
      state_next = state;
      stall_M    = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_op) begin
               stall_M = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
               state_next = addr_bad ? DONE : REQ;
`else
               state_next = REQ;
`endif
            end
         end
         REQ: begin
            stall_M = 1'b1;
            if (dm_ack) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rdata_q <= '0;
      end else begin
         state <= state_next;
         if (state == REQ && dm_ack) rdata_q <= dm_rdata;
      end
   end

   // EX/MEM register: bundle is consumed only on edges where the stage is not stalled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_M     <= 1'b0;
         PCBranch_M  <= '0;
         aluResult_M <= '0;
         writeData_M <= '0;
         zero_M      <= 1'b0;
         Branch_M    <= 1'b0;
         memRead_M   <= 1'b0;
         memWrite_M  <= 1'b0;
         regWrite_M  <= 1'b0;
         memtoReg_M  <= 1'b0;
         rd_M        <= '0;
      end else if (!stall_M) begin
         valid_M     <= valid_E;
         PCBranch_M  <= PCBranch_E;
         aluResult_M <= aluResult_E;
         writeData_M <= writeData_E;
         zero_M      <= zero_E;
         Branch_M    <= Branch_E;
         memRead_M   <= memRead_E;
         memWrite_M  <= memWrite_E;
         regWrite_M  <= regWrite_E;
         memtoReg_M  <= memtoReg_E;
         rd_M        <= rd_E;
      end
   end

   // MEM/WB loads exactly when the stage is not stalled (IDLE with no access, or DONE)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readData_W  <= '0;
         aluResult_W <= '0;
         rd_W        <= '0;
         regWrite_W  <= 1'b0;
         memtoReg_W  <= 1'b0;
      end else if (!stall_M) begin
         readData_W  <= (state == DONE && memRead_M && !misalign_M) ? rdata_q : '0;
         aluResult_W <= aluResult_M;
         rd_W        <= rd_M;
         regWrite_W  <= valid_M & regWrite_M & ~misalign_M;
         memtoReg_W  <= memtoReg_M;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: scoreboard of expected MEM/WB bundles plus handshake checks.
module tb_memory_stage;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_E;
   logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
   logic         zero_E, Branch_E, memRead_E, memWrite_E, regWrite_E, memtoReg_E;
   logic [4:0]   rd_E;
   logic         stall_M, PCSrc_M;
   logic [N-1:0] PCBranch_M;
   logic         dm_req, dm_we;
   logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
   logic         dm_ack;
   logic [N-1:0] readData_W, aluResult_W;
   logic [4:0]   rd_W;
   logic         regWrite_W, memtoReg_W, misalign_M;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic         rw;
      logic         m2r;
      logic [4:0]   rd;
      logic [N-1:0] alu;
      logic [N-1:0] rdat;
   } exp_t;
   exp_t sb[$];

   memory_stage #(.N(N)) dut (
      .clk(clk), .reset(reset), .valid_E(valid_E), .PCBranch_E(PCBranch_E),
      .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
      .Branch_E(Branch_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
      .regWrite_E(regWrite_E), .memtoReg_E(memtoReg_E), .rd_E(rd_E),
      .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .readData_W(readData_W),
      .aluResult_W(aluResult_W), .rd_W(rd_W), .regWrite_W(regWrite_W),
      .memtoReg_W(memtoReg_W), .misalign_M(misalign_M)
   );

   always #5 clk = ~clk;

   // Drives one instruction onto the execute bundle (call at a falling edge) and records its expected W result.
   task automatic send(input logic br, input logic mr, input logic mw, input logic rw, input logic m2r,
                       input logic z, input logic [4:0] rd, input logic [N-1:0] alu,
                       input logic [N-1:0] wdata, input logic [N-1:0] pcb,
                       input bit push, input logic exp_rw, input logic [N-1:0] exp_rdat);
      exp_t e;
      valid_E = 1'b1; Branch_E = br; memRead_E = mr; memWrite_E = mw; regWrite_E = rw;
      memtoReg_E = m2r; zero_E = z; rd_E = rd; aluResult_E = alu; writeData_E = wdata; PCBranch_E = pcb;
      if (push) begin
         e.rw = exp_rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.rdat = exp_rdat;
         sb.push_back(e);
      end
   endtask

   // Clocks the sent instruction through, acting as the memory responder, until MEM/WB loads it.
   task automatic advance(input int ack_delay, input bit hold_ack, input logic [N-1:0] rdata,
                          output int req_cycles, output int stall_cycles, output int edges,
                          output int mis_cycles, output logic [N-1:0] addr0, output logic we0,
                          output logic [N-1:0] wdata0, output bit unstable, output logic pcsrc0,
                          output logic [N-1:0] pcb0, output bit timeout);
      logic stl;
      req_cycles = 0; stall_cycles = 0; mis_cycles = 0; unstable = 0; timeout = 1;
      addr0 = '0; we0 = 1'b0; wdata0 = '0;
      @(posedge clk); edges = 1;
      @(negedge clk);
      valid_E = 1'b0;
      pcsrc0 = PCSrc_M; pcb0 = PCBranch_M;
      for (int i = 0; i < 40; i++) begin
         stl = stall_M;
         if (misalign_M) mis_cycles++;
         if (dm_req) begin
            if (req_cycles == 0) begin
               addr0 = dm_addr; we0 = dm_we; wdata0 = dm_wdata;
            end else if (dm_addr !== addr0 || dm_wdata !== wdata0 || dm_we !== we0) begin
               unstable = 1;
            end
            req_cycles++;
         end
         if (dm_req && req_cycles == ack_delay) begin
            dm_ack = 1'b1; dm_rdata = rdata;
         end else if (!hold_ack) begin
            dm_ack = 1'b0; dm_rdata = '0;
         end
         if (stl) stall_cycles++;
         @(posedge clk); edges++;
         @(negedge clk);
         if (!stl) begin
            timeout = 0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({stall_M, PCSrc_M, dm_req, dm_we, misalign_M, regWrite_W, memtoReg_W} !== 7'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
                           {stall_M, PCSrc_M, dm_req, dm_we, misalign_M, regWrite_W, memtoReg_W});
      end
      n_cmp++;
      if ({dm_addr, dm_wdata, PCBranch_M, readData_W, aluResult_W, rd_W} !== '0) begin
         n_err++; $display("FAIL reset_data: addr=%h wdata=%h pcb=%h rdW=%h aluW=%h rd=%0d want all 0",
                           dm_addr, dm_wdata, PCBranch_M, readData_W, aluResult_W, rd_W);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alu();
      int rq, st, ed, mc; logic [N-1:0] a0, w0, pb; logic we, pc; bit un, to; exp_t e;
      send(0, 0, 0, 1, 0, 0, 5'd3, 64'h2A, 64'h0, 64'h0, 1, 1'b1, 64'h0);
      advance(1, 0, '0, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      n_cmp++;
      if (to || ed !== 2) begin n_err++; $display("FAIL alu_latency: edges=%0d timeout=%0d want 2/0", ed, to); end
      n_cmp++;
      if (st !== 0 || rq !== 0) begin n_err++; $display("FAIL alu_nostall: stall=%0d req=%0d want 0/0", st, rq); end
      e = sb.pop_front();
      n_cmp++;
      if ({regWrite_W, memtoReg_W, rd_W, aluResult_W, readData_W} !== {e.rw, e.m2r, e.rd, e.alu, e.rdat}) begin
         n_err++; $display("FAIL alu_wb: got rw=%b rd=%0d alu=%h rdat=%h want rw=%b rd=%0d alu=%h rdat=%h",
                           regWrite_W, rd_W, aluResult_W, readData_W, e.rw, e.rd, e.alu, e.rdat);
      end
      @(negedge clk);
      n_cmp++;
      if (regWrite_W !== 1'b0 || PCSrc_M !== 1'b0) begin
         n_err++; $display("FAIL bubble: regWrite_W=%b PCSrc_M=%b want 0/0", regWrite_W, PCSrc_M);
      end
   endtask

   task automatic test_load();
      int rq, st, ed, mc; logic [N-1:0] a0, w0, pb; logic we, pc; bit un, to; exp_t e;
      send(0, 1, 0, 1, 1, 0, 5'd9, 64'h100, 64'h0, 64'h0, 1, 1'b1, 64'hDEADBEEF);
      advance(3, 0, 64'hDEADBEEF, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      n_cmp++;
      if (to || rq !== 3 || ed !== 6) begin
         n_err++; $display("FAIL load_req: req_cycles=%0d edges=%0d timeout=%0d want 3/6/0", rq, ed, to);
      end
      n_cmp++;
      if (a0 !== 64'h100 || we !== 1'b0 || un) begin
         n_err++; $display("FAIL load_addr: addr=%h we=%b unstable=%0d want 100/0/0", a0, we, un);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({regWrite_W, memtoReg_W, rd_W, aluResult_W, readData_W} !== {e.rw, e.m2r, e.rd, e.alu, e.rdat}) begin
         n_err++; $display("FAIL load_wb: got rw=%b rd=%0d alu=%h rdat=%h want rw=%b rd=%0d alu=%h rdat=%h",
                           regWrite_W, rd_W, aluResult_W, readData_W, e.rw, e.rd, e.alu, e.rdat);
      end
   endtask

   task automatic test_store();
      int rq, st, ed, mc; logic [N-1:0] a0, w0, pb; logic we, pc; bit un, to; exp_t e;
      send(0, 0, 1, 0, 0, 0, 5'd4, 64'h8, 64'h55, 64'h0, 1, 1'b0, 64'h0);
      advance(1, 0, 64'hFFFF_0000_1234_5678, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      n_cmp++;
      if (to || rq !== 1 || ed !== 4) begin
         n_err++; $display("FAIL store_latency: req_cycles=%0d edges=%0d timeout=%0d want 1/4/0", rq, ed, to);
      end
      n_cmp++;
      if (a0 !== 64'h8 || we !== 1'b1 || w0 !== 64'h55) begin
         n_err++; $display("FAIL store_bus: addr=%h we=%b wdata=%h want 8/1/55", a0, we, w0);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({regWrite_W, memtoReg_W, rd_W, aluResult_W, readData_W} !== {e.rw, e.m2r, e.rd, e.alu, e.rdat}) begin
         n_err++; $display("FAIL store_wb: got rw=%b rd=%0d alu=%h rdat=%h want rw=%b rd=%0d alu=%h rdat=%h",
                           regWrite_W, rd_W, aluResult_W, readData_W, e.rw, e.rd, e.alu, e.rdat);
      end
   endtask

   task automatic test_branch();
      int rq, st, ed, mc; logic [N-1:0] a0, w0, pb; logic we, pc; bit un, to; exp_t e;
      send(1, 0, 0, 0, 0, 1, 5'd0, 64'h0, 64'h0, 64'h40, 1, 1'b0, 64'h0);
      advance(1, 0, '0, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      n_cmp++;
      if (pc !== 1'b1 || pb !== 64'h40) begin
         n_err++; $display("FAIL cbz_taken: PCSrc_M=%b PCBranch_M=%h want 1/40", pc, pb);
      end
      n_cmp++;
      if (PCSrc_M !== 1'b0 || to) begin
         n_err++; $display("FAIL cbz_one_cycle: PCSrc_M=%b timeout=%0d want 0/0", PCSrc_M, to);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({regWrite_W, rd_W, aluResult_W} !== {e.rw, e.rd, e.alu}) begin
         n_err++; $display("FAIL cbz_wb: got rw=%b rd=%0d alu=%h want rw=%b rd=%0d alu=%h",
                           regWrite_W, rd_W, aluResult_W, e.rw, e.rd, e.alu);
      end
      send(1, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h80, 0, 1'b0, 64'h0);
      advance(1, 0, '0, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      n_cmp++;
      if (pc !== 1'b0 || pb !== 64'h80) begin
         n_err++; $display("FAIL cbz_not_taken: PCSrc_M=%b PCBranch_M=%h want 0/80", pc, pb);
      end
   endtask

   task automatic test_ack_held();
      int rq, st, ed, mc, extra; logic [N-1:0] a0, w0, pb; logic we, pc; bit un, to; exp_t e;
      send(0, 1, 0, 1, 1, 0, 5'd17, 64'h1F8, 64'h0, 64'h0, 1, 1'b1, 64'hCAFE_F00D_0123_4567);
      advance(1, 1, 64'hCAFE_F00D_0123_4567, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      e = sb.pop_front();
      n_cmp++;
      if ({regWrite_W, memtoReg_W, rd_W, aluResult_W, readData_W} !== {e.rw, e.m2r, e.rd, e.alu, e.rdat}) begin
         n_err++; $display("FAIL ackheld_wb: got rw=%b rd=%0d alu=%h rdat=%h want rw=%b rd=%0d alu=%h rdat=%h",
                           regWrite_W, rd_W, aluResult_W, readData_W, e.rw, e.rd, e.alu, e.rdat);
      end
      extra = 0;
      repeat (4) begin
         if (dm_req || stall_M) extra++;
         @(negedge clk);
      end
      dm_ack = 1'b0; dm_rdata = '0;
      n_cmp++;
      if (rq !== 1 || extra !== 0 || ed !== 4) begin
         n_err++; $display("FAIL ackheld_single: req=%0d extra=%0d edges=%0d want 1/0/4", rq, extra, ed);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int stalls;
      stalls = 0;
      send(0, 0, 0, 1, 0, 0, 5'd5, 64'h1111, 64'h0, 64'h0, 1, 1'b1, 64'h0);
      @(negedge clk);
      if (stall_M) stalls++;
      send(0, 0, 0, 1, 0, 0, 5'd6, 64'h2222, 64'h0, 64'h0, 1, 1'b1, 64'h0);
      @(negedge clk);
      if (stall_M) stalls++;
      valid_E = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if ({regWrite_W, rd_W, aluResult_W} !== {e.rw, e.rd, e.alu}) begin
            n_err++; $display("FAIL b2b_wb%0d: got rw=%b rd=%0d alu=%h want rw=%b rd=%0d alu=%h",
                              k, regWrite_W, rd_W, aluResult_W, e.rw, e.rd, e.alu);
         end
         if (stall_M) stalls++;
         @(negedge clk);
      end
      n_cmp++;
      if (stalls !== 0) begin n_err++; $display("FAIL b2b_stall: stall cycles=%0d want 0", stalls); end
   endtask

   task automatic test_reset_mid_req();
      bit seen;
      int bad;
      seen = 0; bad = 0;
      send(0, 1, 0, 1, 1, 0, 5'd12, 64'h200, 64'h0, 64'h0, 0, 1'b0, 64'h0);
      @(negedge clk);
      valid_E = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (dm_req) seen = 1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!seen) begin n_err++; $display("FAIL rst_req_seen: dm_req=%b want 1 within 10 cycles", dm_req); end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (dm_req !== 1'b0 || stall_M !== 1'b0) begin
         n_err++; $display("FAIL rst_async: dm_req=%b stall_M=%b want 0/0", dm_req, stall_M);
      end
      @(negedge clk);
      reset = 1'b1;
      dm_ack = 1'b1; dm_rdata = 64'hBAD;
      repeat (4) begin
         if (dm_req || stall_M || regWrite_W || readData_W !== '0) bad++;
         @(negedge clk);
      end
      dm_ack = 1'b0; dm_rdata = '0;
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL rst_abandon: active cycles=%0d want 0", bad); end
   endtask

   task automatic test_misalign();
      int rq, st, ed, mc; logic [N-1:0] a0, w0, pb; logic we, pc; bit un, to; exp_t e;
`ifdef MEM_ALIGN_CHECK_EN
      send(0, 1, 0, 1, 1, 0, 5'd7, 64'h103, 64'h0, 64'h0, 1, 1'b0, 64'h0);
      advance(1, 0, 64'h1234, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      n_cmp++;
      if (to || rq !== 0 || mc !== 1) begin
         n_err++; $display("FAIL misalign_flag: req=%0d misalign_cycles=%0d timeout=%0d want 0/1/0", rq, mc, to);
      end
`else
      send(0, 1, 0, 1, 1, 0, 5'd7, 64'h103, 64'h0, 64'h0, 1, 1'b1, 64'h1234);
      advance(1, 0, 64'h1234, rq, st, ed, mc, a0, we, w0, un, pc, pb, to);
      n_cmp++;
      if (to || rq !== 1 || mc !== 0 || a0 !== 64'h103) begin
         n_err++; $display("FAIL misalign_issue: req=%0d misalign_cycles=%0d addr=%h timeout=%0d want 1/0/103/0",
                           rq, mc, a0, to);
      end
`endif
      e = sb.pop_front();
      n_cmp++;
      if ({regWrite_W, rd_W, aluResult_W, readData_W} !== {e.rw, e.rd, e.alu, e.rdat}) begin
         n_err++; $display("FAIL misalign_wb: got rw=%b rd=%0d alu=%h rdat=%h want rw=%b rd=%0d alu=%h rdat=%h",
                           regWrite_W, rd_W, aluResult_W, readData_W, e.rw, e.rd, e.alu, e.rdat);
      end
   endtask

   initial begin
      valid_E = 0; PCBranch_E = '0; aluResult_E = '0; writeData_E = '0; zero_E = 0;
      Branch_E = 0; memRead_E = 0; memWrite_E = 0; regWrite_E = 0; memtoReg_E = 0; rd_E = '0;
      dm_rdata = '0; dm_ack = 0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_branch();
      test_ack_held();
      test_back_to_back();
      test_reset_mid_req();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
